// File: rtl/lcd_scan_gfx.sv
// lcd_scan_gfx - graphics layer refresh engine for the S1D13700 core.
//
// The block fetches one VRAM byte at a time through the shared read port.
// It shifts each byte out as two nibbles on the LCD data bus, high nibble
// first, and generates the XSCL, LP and YD panel timing. Screen geometry
// (sad/cr/lf/ap) is copied into shadow registers at each frame start, so
// register writes made mid-frame take effect from the next frame.
//
// Ports
//   clk        system clock, rising edge
//   rst_x      asynchronous active-low reset
//   en         display on; 0 returns the engine to IDLE on the next edge
//   sad        screen start address
//   cr         bytes per line minus 1
//   lf         lines per frame minus 1
//   ap         line-to-line address pitch (zero-extended)
//   mpu_acc    MPU claims the shared VRAM port
//   vram_ce    VRAM read chip enable
//   vram_addr  VRAM read address
//   vram_do    VRAM read data, valid the cycle after vram_ce
//   lcd_d      panel data nibble
//   lcd_xscl   nibble shift clock (panel samples on rising edge)
//   lcd_lp     line latch pulse (2 cycles)
//   lcd_yd     frame marker, high during the LP of the last line
module lcd_scan_gfx (
    input  logic        clk,
    input  logic        rst_x,
    input  logic        en,
    input  logic [12:0] sad,
    input  logic [7:0]  cr,
    input  logic [7:0]  lf,
    input  logic [7:0]  ap,
    input  logic        mpu_acc,
    output logic        vram_ce,
    output logic [12:0] vram_addr,
    input  logic [7:0]  vram_do,
    output logic [3:0]  lcd_d,
    output logic        lcd_xscl,
    output logic        lcd_lp,
    output logic        lcd_yd
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_DAT  = 3'd2,
        ST_SH   = 3'd3,
        ST_LP   = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [7:0]  col_r, col_s;
    logic [7:0]  line_r, line_s;
    logic [12:0] line_addr_r, line_addr_s;
    logic [12:0] byte_addr_r, byte_addr_s;
    logic [3:0]  sreg_r, sreg_s;
    logic [1:0]  ph_r, ph_s;
    logic [7:0]  cr_sh_r, cr_sh_s;
    logic [7:0]  lf_sh_r, lf_sh_s;
    logic [7:0]  ap_sh_r, ap_sh_s;

    logic        vram_ce_r, vram_ce_s;
    logic [12:0] vram_addr_r, vram_addr_s;
    logic [3:0]  lcd_d_r, lcd_d_s;
    logic        lcd_xscl_r, lcd_xscl_s;
    logic        lcd_lp_r, lcd_lp_s;
    logic        lcd_yd_r, lcd_yd_s;

    // State register
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; RD only advances once a read was actually issued
    always_comb begin
        state_s = state_r;
        if (!en) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_s = ST_RD;
                ST_RD:   state_s = vram_ce_r ? ST_DAT : ST_RD;
                ST_DAT:  state_s = ST_SH;
                ST_SH: begin
                    if (ph_r == 2'd3) begin
                        state_s = (col_r == cr_sh_r) ? ST_LP : ST_RD;
                    end else begin
                        state_s = ST_SH;
                    end
                end
                ST_LP:   state_s = ph_r[0] ? ST_RD : ST_LP;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Datapath next values: counters, addresses, nibble hold, shadows
    always_comb begin
        col_s       = col_r;
        line_s      = line_r;
        line_addr_s = line_addr_r;
        byte_addr_s = byte_addr_r;
        sreg_s      = sreg_r;
        ph_s        = ph_r;
        cr_sh_s     = cr_sh_r;
        lf_sh_s     = lf_sh_r;
        ap_sh_s     = ap_sh_r;
        if (en) begin
            case (state_r)
                ST_IDLE: begin
                    cr_sh_s     = cr;
                    lf_sh_s     = lf;
                    ap_sh_s     = ap;
                    line_addr_s = sad;
                    byte_addr_s = sad;
                    line_s      = 8'd0;
                    col_s       = 8'd0;
                end
                ST_RD: begin
                    ph_s = ph_r;
                end
                ST_DAT: begin
                    sreg_s = vram_do[3:0];
                    ph_s   = 2'd0;
                end
                ST_SH: begin
                    // ph wraps 3->0, so LP starts with ph=0
                    ph_s = ph_r + 2'd1;
                    if ((ph_r == 2'd3) && (col_r != cr_sh_r)) begin
                        col_s       = col_r + 8'd1;
                        byte_addr_s = byte_addr_r + 13'd1;
                    end else begin
                        col_s = col_r;
                    end
                end
                ST_LP: begin
                    ph_s = ph_r + 2'd1;
                    if (ph_r[0]) begin
                        col_s = 8'd0;
                        if (line_r == lf_sh_r) begin
                            // frame start: take fresh geometry
                            line_s      = 8'd0;
                            cr_sh_s     = cr;
                            lf_sh_s     = lf;
                            ap_sh_s     = ap;
                            line_addr_s = sad;
                            byte_addr_s = sad;
                        end else begin
                            line_s      = line_r + 8'd1;
                            line_addr_s = line_addr_r + {5'd0, ap_sh_r};
                            byte_addr_s = line_addr_r + {5'd0, ap_sh_r};
                        end
                    end else begin
                        col_s = col_r;
                    end
                end
                default: begin
                    ph_s = 2'd0;
                end
            endcase
        end else begin
            ph_s = ph_r;
        end
    end

    // Output next values, decoded from the state being entered so that every
    // output is a register. vram_ce for an RD cycle is decided at the edge
    // entering it, so mpu_acc is taken as the claim on the port for that
    // coming cycle.
    always_comb begin
        vram_ce_s   = 1'b0;
        vram_addr_s = vram_addr_r;
        lcd_d_s     = lcd_d_r;
        lcd_xscl_s  = 1'b0;
        lcd_lp_s    = 1'b0;
        lcd_yd_s    = 1'b0;
        if (state_s == ST_IDLE) begin
            vram_addr_s = 13'd0;
            lcd_d_s     = 4'd0;
        end else begin
            if (state_s == ST_RD) begin
                vram_ce_s   = !mpu_acc;
                vram_addr_s = byte_addr_s;
            end else begin
                vram_ce_s = 1'b0;
            end
            // lcd_d moves at ph0/ph2 entry, one cycle before xscl rises
            if (state_r == ST_DAT) begin
                lcd_d_s = vram_do[7:4];
            end else if ((state_r == ST_SH) && (ph_r == 2'd1)) begin
                lcd_d_s = sreg_r;
            end else begin
                lcd_d_s = lcd_d_r;
            end
            lcd_xscl_s = (state_s == ST_SH) && ph_s[0];
            lcd_lp_s   = (state_s == ST_LP);
            lcd_yd_s   = (state_s == ST_LP) && (line_r == lf_sh_r);
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            col_r       <= 8'd0;
            line_r      <= 8'd0;
            line_addr_r <= 13'd0;
            byte_addr_r <= 13'd0;
            sreg_r      <= 4'd0;
            ph_r        <= 2'd0;
            cr_sh_r     <= 8'd0;
            lf_sh_r     <= 8'd0;
            ap_sh_r     <= 8'd0;
            vram_ce_r   <= 1'b0;
            vram_addr_r <= 13'd0;
            lcd_d_r     <= 4'd0;
            lcd_xscl_r  <= 1'b0;
            lcd_lp_r    <= 1'b0;
            lcd_yd_r    <= 1'b0;
        end else begin
            col_r       <= col_s;
            line_r      <= line_s;
            line_addr_r <= line_addr_s;
            byte_addr_r <= byte_addr_s;
            sreg_r      <= sreg_s;
            ph_r        <= ph_s;
            cr_sh_r     <= cr_sh_s;
            lf_sh_r     <= lf_sh_s;
            ap_sh_r     <= ap_sh_s;
            vram_ce_r   <= vram_ce_s;
            vram_addr_r <= vram_addr_s;
            lcd_d_r     <= lcd_d_s;
            lcd_xscl_r  <= lcd_xscl_s;
            lcd_lp_r    <= lcd_lp_s;
            lcd_yd_r    <= lcd_yd_s;
        end
    end

    assign vram_ce   = vram_ce_r;
    assign vram_addr = vram_addr_r;
    assign lcd_d     = lcd_d_r;
    assign lcd_xscl  = lcd_xscl_r;
    assign lcd_lp    = lcd_lp_r;
    assign lcd_yd    = lcd_yd_r;

endmodule
